seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-anode multi-digit 7-segment display on the stopwatch board. It shares one external hex-to-7-segment decoder between all digits. Each scan slot it presents one digit's nibble to the decoder, drives the matching active-low anode, and gates the segments off during a guard interval to prevent ghosting. The display value is double-buffered and only changes at frame boundaries. Optional leading-zero blanking.

Parameters:
DIGITS, 4, number of display digits (1..8); digit 0 = rightmost/least significant
SCAN_DIV, 50000, clk cycles per digit SHOW slot (>=2)
GUARD, 500, clk cycles all anodes off before each SHOW slot (>=1)

Ports:
clk  in  1  system clock; one clock domain
reset  in  1  synchronous, active-high reset
enable  in  1  1 = scan display; 0 = all digits dark
value  in  4*DIGITS  digit nibbles; digit i = value[4i+3:4i]
dp_mask  in  DIGITS  decimal point per digit, 1 = lit
load  in  1  1-cycle strobe; captures value/dp_mask into pending buffer
lzb_en  in  1  1 = blank leading zero digits
nibble  out  4  to decoder number input
seg_blank  out  1  1 = force all decoder segment outputs off (inactive high)
an_n  out  DIGITS  anode enables, active low
dp_n  out  1  decimal point, active low
frame_done  out  1  1-cycle pulse at end of each full scan frame

Behaviour:
- Only clk is used. Reset is synchronous and active-high. All outputs are registered.
- Reset values: an_n all 1, dp_n 1, seg_blank 1, nibble 0, frame_done 0, state IDLE, idx 0, counters 0, pending/active buffers 0.
- Buffers: load writes value/dp_mask into pending on any cycle. Pending is copied to active on frame start, i.e. the transition into GUARD for idx 0. If load coincides with frame start, the new load data goes directly to active (bypass).
- States:
  - IDLE: an_n all 1, seg_blank 1. When enable=1: go to GUARD, idx=0, and perform a frame start.
  - GUARD: an_n all 1, seg_blank 1, nibble = active digit idx. Lasts GUARD cycles, then go to SHOW.
  - SHOW: an_n[idx]=0 (others 1), nibble = active digit idx, dp_n = ~dp[idx], seg_blank = blanked(idx). Lasts SCAN_DIV cycles.
- End of SHOW:
  - idx < DIGITS-1: idx+1, go to GUARD.
  - idx = DIGITS-1: idx wraps to 0, go to GUARD, frame_done=1 for exactly that cycle, and perform a frame start.
- Frame period is DIGITS*(GUARD+SCAN_DIV) cycles.
- Leading-zero blanking: with lzb_en=1, digit i is blanked if it and all digits above it are 0. Digit 0 is never blanked. lzb_en is sampled at frame start.
- A blanked digit still drives its anode low, but seg_blank=1 and dp_n=1 (its DP is suppressed).
- enable dropping to 0 in any state: next cycle goes to IDLE with an_n all 1. The current frame is abandoned and no frame_done is issued. Re-enable always restarts at digit 0.
- reset asserted mid-frame: next cycle matches the reset values regardless of state.
- Cycle counter width is $clog2(max(SCAN_DIV,GUARD)). Counters never wrap mid-slot.
- At most one anode is low at any cycle (invariant for the bench).

Test Plan:
- DIGITS=4, SCAN_DIV=4, GUARD=1. Reset, then enable=1, load value=16'h1234 -> first SHOW shows an_n=4'b1110 with nibble 4; then 3, 2, 1 on an_n 1101/1011/0111; each slot is 4 cycles preceded by 1 all-off cycle; frame_done pulses every 20 cycles.
- Mid-frame, load value=16'hABCD while digit 1 is shown -> digits 2 and 3 of the current frame still show 2 and 1; the next frame shows D, C, B, A.
- lzb_en=1, value=16'h0050 -> digits 3 and 2 have seg_blank=1 with an_n toggling; digits 1 and 0 show 5 and 0. value=16'h0000 -> only digit 0 is unblanked, showing 0.
- dp_mask=4'b0100, value=16'h1234 -> dp_n=0 only during the SHOW of digit 2; dp_n=1 during all GUARD cycles.
- Drop enable for one cycle during SHOW of digit 2 -> an_n goes to all 1 the next cycle, no frame_done, and scan restarts at digit 0 with GUARD. Assert reset mid-SHOW -> outputs take their reset values the next cycle.
- Load coincident with the frame_done cycle -> the new value is shown in the immediately starting frame (bypass).

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Time-multiplexed scan controller for a common-anode multi-digit
//   7-segment display sharing one external hex-to-7-segment decoder.
//   Each digit slot is a GUARD interval (all anodes off, segments blanked)
//   followed by a SHOW interval (one anode low, its nibble presented).
//   The display value is double-buffered: load fills a pending buffer, and
//   the pending buffer is copied to the active buffer at each frame start.
//   Optional leading-zero blanking is latched at frame start.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   enable      1 = scan, 0 = all digits dark (returns to IDLE)
//   value       digit nibbles, digit i = value[4i+3:4i]
//   dp_mask     decimal point per digit, 1 = lit
//   load        1-cycle strobe capturing value/dp_mask into pending
//   lzb_en      1 = blank leading zero digits
//   nibble      number presented to the decoder
//   seg_blank   1 = decoder segment outputs forced off
//   an_n        anode enables, active low
//   dp_n        decimal point, active low
//   frame_done  1-cycle pulse during the final cycle of a full frame
module seg_scan_ctrl #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned GUARD    = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  load,
  input  logic                  lzb_en,
  output logic [3:0]            nibble,
  output logic                  seg_blank,
  output logic [DIGITS-1:0]     an_n,
  output logic                  dp_n,
  output logic                  frame_done
);

  localparam int unsigned CMAX = (SCAN_DIV > GUARD) ? SCAN_DIV : GUARD;
  localparam int unsigned CW   = $clog2(CMAX);
  localparam int unsigned IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] G_LAST = CW'(GUARD - 1);
  localparam logic [CW-1:0] S_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] D_LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_GUARD, S_SHOW} state_t;

  state_t              state, nstate;
  logic [IW-1:0]       idx, nidx;
  logic [CW-1:0]       cnt, ncnt;
  logic [4*DIGITS-1:0] pend_v, npend_v, act_v, nact_v;
  logic [DIGITS-1:0]   pend_dp, npend_dp, act_dp, nact_dp;
  logic                lzb_q, nlzb;
  logic                fstart;
  logic [DIGITS-1:0]   nblank;

  logic [3:0]          nib_nx;
  logic                sb_nx, dp_nx, fd_nx;
  logic [DIGITS-1:0]   an_nx;

  // Digit i is blanked when it and every higher digit are zero; digit 0 never.
  function automatic logic [DIGITS-1:0] blank_mask(input logic [4*DIGITS-1:0] v,
                                                    input logic lz);
    logic [DIGITS-1:0] m;
    logic              all_zero;
    int unsigned       i;
    m        = '0;
    all_zero = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      i        = DIGITS - 1 - k;
      all_zero = all_zero & (v[4*i +: 4] == 4'h0);
      m[i]     = lz & all_zero & (i != 0);
    end
    return m;
  endfunction

  // Next-state, next-buffer and next-output logic. Outputs are registered
  // from the next-cycle state so they line up with the state they describe.
  always_comb begin
    nstate   = state;
    nidx     = idx;
    ncnt     = cnt;
    fstart   = 1'b0;
    npend_v  = load ? value   : pend_v;
    npend_dp = load ? dp_mask : pend_dp;
    nact_v   = act_v;
    nact_dp  = act_dp;
    nlzb     = lzb_q;

    if (!enable) begin
      nstate = S_IDLE;
      nidx   = '0;
      ncnt   = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          nstate = S_GUARD;
          nidx   = '0;
          ncnt   = '0;
          fstart = 1'b1;
        end
        S_GUARD: begin
          if (cnt == G_LAST) begin
            nstate = S_SHOW;
            ncnt   = '0;
          end else begin
            ncnt = cnt + 1'b1;
          end
        end
        S_SHOW: begin
          if (cnt == S_LAST) begin
            nstate = S_GUARD;
            ncnt   = '0;
            if (idx == D_LAST) begin
              nidx   = '0;
              fstart = 1'b1;
            end else begin
              nidx = idx + 1'b1;
            end
          end else begin
            ncnt = cnt + 1'b1;
          end
        end
        default: begin
          nstate = S_IDLE;
          nidx   = '0;
          ncnt   = '0;
        end
      endcase
    end

    // A load on the frame-start cycle bypasses pending straight to active.
    if (fstart) begin
      nact_v  = load ? value   : pend_v;
      nact_dp = load ? dp_mask : pend_dp;
      nlzb    = lzb_en;
    end

    nblank = blank_mask(nact_v, nlzb);

    an_nx  = '1;
    dp_nx  = 1'b1;
    sb_nx  = 1'b1;
    nib_nx = '0;
    fd_nx  = 1'b0;
    unique case (nstate)
      S_GUARD: nib_nx = nact_v[4*nidx +: 4];
      S_SHOW: begin
        nib_nx      = nact_v[4*nidx +: 4];
        an_nx[nidx] = 1'b0;
        sb_nx       = nblank[nidx];
        dp_nx       = nblank[nidx] | ~nact_dp[nidx];
        fd_nx       = (nidx == D_LAST) && (ncnt == S_LAST);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      cnt        <= '0;
      pend_v     <= '0;
      pend_dp    <= '0;
      act_v      <= '0;
      act_dp     <= '0;
      lzb_q      <= 1'b0;
      an_n       <= '1;
      dp_n       <= 1'b1;
      seg_blank  <= 1'b1;
      nibble     <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= nstate;
      idx        <= nidx;
      cnt        <= ncnt;
      pend_v     <= npend_v;
      pend_dp    <= npend_dp;
      act_v      <= nact_v;
      act_dp     <= nact_dp;
      lzb_q      <= nlzb;
      an_n       <= an_nx;
      dp_n       <= dp_nx;
      seg_blank  <= sb_nx;
      nibble     <= nib_nx;
      frame_done <= fd_nx;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned GUARD    = 1;
  localparam int unsigned SLOT     = GUARD + SCAN_DIV;
  localparam int unsigned FRAME    = DIGITS * SLOT;

  logic                clk = 1'b0;
  logic                reset, enable, load, lzb_en;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp_mask;
  logic [3:0]          nibble;
  logic                seg_blank, dp_n, frame_done;
  logic [DIGITS-1:0]   an_n;

  int tests  = 0;
  int failed = 0;

  seg_scan_ctrl #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD)) dut (
    .clk(clk), .reset(reset), .enable(enable), .value(value),
    .dp_mask(dp_mask), .load(load), .lzb_en(lzb_en), .nibble(nibble),
    .seg_blank(seg_blank), .an_n(an_n), .dp_n(dp_n), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Reference model: position within the frame plus the two buffers.
  bit                  run;
  int unsigned         p;
  logic [4*DIGITS-1:0] mact, mpend;
  logic [DIGITS-1:0]   mdp, mpdp;
  logic                mlzb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      if (failed <= 30)
        $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_update();
    bit fs;
    if (reset) begin
      run = 0; p = 0; mact = '0; mpend = '0; mdp = '0; mpdp = '0; mlzb = 1'b0;
    end else begin
      fs = 0;
      if (!enable) run = 0;
      else if (!run) begin run = 1; p = 0; fs = 1; end
      else begin
        p++;
        if (p == FRAME) begin p = 0; fs = 1; end
      end
      if (fs) begin
        mact = load ? value : mpend;
        mdp  = load ? dp_mask : mpdp;
        mlzb = lzb_en;
      end
      if (load) begin mpend = value; mpdp = dp_mask; end
    end
  endtask

  task automatic compare_all();
    int unsigned d, w;
    logic [DIGITS-1:0] e_an;
    logic [3:0]        e_nib;
    logic              e_sb, e_dp, e_fd, blank;
    logic [4*DIGITS-1:0] upper;
    e_an = '1; e_nib = 4'h0; e_sb = 1'b1; e_dp = 1'b1; e_fd = 1'b0;
    if (run) begin
      d     = p / SLOT;
      w     = p % SLOT;
      upper = mact >> (4 * d);
      e_nib = upper[3:0];
      blank = mlzb && (d > 0) && (upper == '0);
      if (w >= GUARD) begin
        e_an    = ~(DIGITS'(1) << d);
        e_sb    = blank;
        e_dp    = blank ? 1'b1 : ~mdp[d];
      end
      e_fd = (p == FRAME - 1);
    end
    check("an_n",       32'(an_n),       32'(e_an));
    check("nibble",     32'(nibble),     32'(e_nib));
    check("seg_blank",  32'(seg_blank),  32'(e_sb));
    check("dp_n",       32'(dp_n),       32'(e_dp));
    check("frame_done", 32'(frame_done), 32'(e_fd));
    check("one_anode",  32'($countones(~an_n) <= 1), 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1 compare_all();
    @(negedge clk);
    load = 1'b0;
  endtask

  // Advance until the model is in SHOW of digit d (bounded).
  task automatic wait_show(input int unsigned d);
    for (int n = 0; n < 2 * FRAME; n++) begin
      if (run && (p / SLOT == d) && (p % SLOT >= GUARD)) return;
      step();
    end
    check("wait_show_timeout", 32'd0, 32'd1);
  endtask

  task automatic load_val(input logic [15:0] v, input logic [3:0] dp);
    value = v; dp_mask = dp; load = 1'b1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; load = 1'b0; lzb_en = 1'b0;
    value = '0; dp_mask = '0;
    run = 0; p = 0; mact = '0; mpend = '0; mdp = '0; mpdp = '0; mlzb = 1'b0;
    @(negedge clk);
    step(); step();

    // Basic scan of 1234
    reset = 1'b0; enable = 1'b1; load_val(16'h1234, 4'b0000);
    repeat (45) step();

    // Mid-frame load: current frame unchanged, next frame shows ABCD
    wait_show(1);
    load_val(16'hABCD, 4'b0000);
    repeat (45) step();

    // Leading-zero blanking
    lzb_en = 1'b1; load_val(16'h0050, 4'b1111);
    repeat (45) step();
    load_val(16'h0000, 4'b1111);
    repeat (45) step();

    // Decimal point on digit 2 only
    lzb_en = 1'b0; load_val(16'h1234, 4'b0100);
    repeat (45) step();

    // Enable drop during SHOW of digit 2
    wait_show(2);
    enable = 1'b0; step();
    enable = 1'b1; repeat (25) step();

    // Reset mid-SHOW
    wait_show(1);
    reset = 1'b1; step();
    reset = 1'b0; repeat (25) step();

    // Load coincident with the frame_done cycle goes straight to active
    for (int n = 0; n < 2 * FRAME && !(run && p == FRAME - 1); n++) step();
    load_val(16'h9876, 4'b1001);
    repeat (25) step();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset  = ($urandom_range(0, 299) == 0);
      enable = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 149) == 0) lzb_en = ~lzb_en;
      if ($urandom_range(0, 24) == 0 || (run && p == FRAME - 1 && $urandom_range(0, 1) == 1)) begin
        for (int i = 0; i < DIGITS; i++)
          value[4*i +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
        dp_mask = DIGITS'($urandom);
        load    = 1'b1;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
